// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and types for the program-counter unit.
//               Holds the default address width, the reset and exception
//               vectors, and the next-PC source select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int unsigned c_XLEN         = 32;
  localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] c_EXC_VECTOR   = 32'h0000_0080;

  // Next-PC source, listed from the default case upward.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_ERET = 3'd5
  } next_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. A push writes at the pointer
//               and advances it; once the stack is full, a push overwrites the
//               oldest entry and sets the sticky overflow flag. A pop on an
//               empty stack does nothing.
// Ports       : clk, rst_n (async, active-low)
//               push, pop        - single-cycle commands (push wins if both)
//               push_data        - address to record
//               top              - newest entry, 0 when empty
//               valid            - stack non-empty
//               overflow         - sticky, set when a push drops an entry
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid,
  output logic            overflow
);

  localparam int unsigned c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned c_CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]    r_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;       // next slot to write
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_overflow;

  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_full;

  // Depth is a power of two, so the pointer wraps for free.
  assign w_top_idx = r_ptr - c_PTR_W'(1);
  assign w_full    = (r_cnt == c_CNT_W'(RAS_DEPTH));
  assign valid     = (r_cnt != '0);
  assign top       = valid ? r_mem[w_top_idx] : '0;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + c_PTR_W'(1);
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end else if (pop && valid) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter register with next-PC resolution from
//               sequential, branch, jump and jump-register sources, plus a
//               return-address stack that predicts jr $ra targets.
//               Optional exception entry/return is compiled in with the
//               PC_EXC_EN macro (adds exc, eret, epc and EXC_VECTOR).
// Ports       : clk, rst_n (async, active-low), stall
//               branch, zero, jump, link, jr, is_ret  - decoded controls
//               jr_target, imm16, addr26               - target operands
//               pc, pc_plus4                           - current PC / PC+4
//               ras_top, ras_valid, ras_mispredict, ras_overflow
//               [PC_EXC_EN] exc, eret, epc
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned XLEN         = c_XLEN,
  parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR,
  parameter int unsigned RAS_DEPTH    = 4
`ifdef PC_EXC_EN
  ,
  parameter logic [31:0] EXC_VECTOR   = c_EXC_VECTOR
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            link,
  input  logic            jr,
  input  logic            is_ret,
  input  logic [XLEN-1:0] jr_target,
  input  logic [15:0]     imm16,
  input  logic [25:0]     addr26,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ras_mispredict,
  output logic            ras_overflow
`ifdef PC_EXC_EN
  ,
  input  logic            exc,
  input  logic            eret,
  output logic [XLEN-1:0] epc
`endif
);

  localparam logic [XLEN-1:0] c_RST_PC = XLEN'(RESET_VECTOR);

  logic [XLEN-1:0] r_pc;
  logic            r_mispredict;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_j_tgt;
  logic [XLEN-1:0] w_next_pc;
  next_sel_e       w_sel;
  logic            w_update;
  logic            w_push;
  logic            w_pop;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  // Word offset: sign-extend the 16-bit immediate, then scale by 4.
  assign w_br_off   = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;

  // The jump keeps the region bits above bit 27; with a 28-bit PC there are none.
  generate
    if (XLEN > 28) begin : g_jtgt_region
      assign w_j_tgt = {w_pc_plus4[XLEN-1:28], addr26, 2'b00};
    end else begin : g_jtgt_flat
      assign w_j_tgt = {addr26, 2'b00};
    end
  endgenerate

`ifdef PC_EXC_EN
  logic [XLEN-1:0] r_epc;
  localparam logic [XLEN-1:0] c_EXC_PC = XLEN'(EXC_VECTOR);
`endif

  always_comb begin
    w_sel = SEL_SEQ;
`ifdef PC_EXC_EN
    if (exc) begin
      w_sel = SEL_EXC;
    end else if (eret) begin
      w_sel = SEL_ERET;
    end else
`endif
    if (branch && zero) begin
      w_sel = SEL_BR;
    end else if (jump) begin
      w_sel = SEL_J;
    end else if (jr) begin
      w_sel = SEL_JR;
    end
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      SEL_BR:   w_next_pc = w_br_tgt;
      SEL_J:    w_next_pc = w_j_tgt;
      SEL_JR:   w_next_pc = jr_target;
`ifdef PC_EXC_EN
      SEL_EXC:  w_next_pc = c_EXC_PC;
      SEL_ERET: w_next_pc = r_epc;
`endif
      default:  w_next_pc = w_pc_plus4;
    endcase
  end

  // Exception entry/return bypass stall; everything else waits on it.
  assign w_update = !stall || (w_sel == SEL_EXC) || (w_sel == SEL_ERET);
  // The select already excludes exc/eret, so the RAS is left alone then.
  assign w_push   = !stall && (w_sel == SEL_J)  && link;
  assign w_pop    = !stall && (w_sel == SEL_JR) && is_ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= c_RST_PC;
      r_mispredict <= 1'b0;
    end else begin
      if (w_update) begin
        r_pc <= w_next_pc;
      end
      // Clears itself the following cycle and whenever stalled.
      r_mispredict <= w_pop && ras_valid && (ras_top != jr_target);
    end
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc <= '0;
    end else if (w_sel == SEL_EXC) begin
      r_epc <= r_pc;
    end
  end

  assign epc = r_epc;
`endif

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid),
    .overflow  (ras_overflow)
  );

  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign ras_mispredict = r_mispredict;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit (default build, XLEN=32,
//               RESET_VECTOR=0, RAS_DEPTH=4). Each step computes the expected
//               post-edge state with an independent model and queues it; the
//               entry is popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, zero, jump, link, jr, is_ret;
  logic [31:0] jr_target;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, ras_mispredict, ras_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] top;
    logic        mis;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];

  // Model state: stack as a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch         (branch),
    .zero           (zero),
    .jump           (jump),
    .link           (link),
    .jr             (jr),
    .is_ret         (is_ret),
    .jr_target      (jr_target),
    .imm16          (imm16),
    .addr26         (addr26),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .ras_top        (ras_top),
    .ras_valid      (ras_valid),
    .ras_mispredict (ras_mispredict),
    .ras_overflow   (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, ".pc"},    pc,                    e.pc);
    check({tag, ".valid"}, {31'b0, ras_valid},     {31'b0, e.valid});
    check({tag, ".top"},   ras_top,               e.top);
    check({tag, ".mis"},   {31'b0, ras_mispredict}, {31'b0, e.mis});
    check({tag, ".ovf"},   {31'b0, ras_overflow},  {31'b0, e.ovf});
  endtask

  // One clock of stimulus: drive, predict, wait for the edge, compare.
  task automatic step(input string tag, input bit st, input bit br, input bit z,
                      input bit j, input bit l, input bit r, input bit ret,
                      input logic [31:0] jt, input logic [15:0] imm, input logic [25:0] a26);
    logic [31:0] ppl4, npc;
    logic        mis;
    exp_t        e;
    stall = st; branch = br; zero = z; jump = j; link = l;
    jr = r; is_ret = ret; jr_target = jt; imm16 = imm; addr26 = a26;

    ppl4 = m_pc + 32'd4;
    npc  = m_pc;
    mis  = 1'b0;
    if (!st) begin
      if (br && z) begin
        npc = ppl4 + {{14{imm[15]}}, imm, 2'b00};
      end else if (j) begin
        npc = {ppl4[31:28], a26, 2'b00};
        if (l) begin
          if (m_stack.size() == 4) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
          m_stack.push_back(ppl4);
        end
      end else if (r) begin
        npc = jt;
        if (ret && m_stack.size() > 0) begin
          mis = (m_stack[$] != jt);
          void'(m_stack.pop_back());
        end
      end else begin
        npc = ppl4;
      end
      m_pc = npc;
    end
    e.pc    = m_pc;
    e.valid = (m_stack.size() > 0);
    e.top   = (m_stack.size() > 0) ? m_stack[$] : 32'h0;
    e.mis   = mis;
    e.ovf   = m_ovf;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_state(tag, e);
    end
  endtask

  task automatic seq(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
  endtask

  task automatic go(input logic [31:0] a);
    step("go", 0, 0, 0, 0, 0, 1, 0, a, 16'h0, 26'h0);
  endtask

  task automatic jal(input string tag, input logic [25:0] a26);
    step(tag, 0, 0, 0, 1, 1, 0, 0, 32'h0, 16'h0, a26);
  endtask

  task automatic ret(input string tag, input logic [31:0] jt);
    step(tag, 0, 0, 0, 0, 0, 1, 1, jt, 16'h0, 26'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e0;
    logic [31:0] want_ret;
    rst_n = 1'b0;
    stall = 0; branch = 0; zero = 0; jump = 0; link = 0; jr = 0; is_ret = 0;
    jr_target = '0; imm16 = '0; addr26 = '0;
    model_reset();
    #2;
    e0 = '{pc: 32'h0, valid: 1'b0, top: 32'h0, mis: 1'b0, ovf: 1'b0};
    check_state("reset", e0);
    #10 rst_n = 1'b1;   // t=12, between edges

    // Sequential from the reset vector
    seq("seq1"); seq("seq2"); seq("seq3");

    // Branches, negative offset taken / not taken
    go(32'h40);
    step("br_neg", 0, 1, 1, 0, 0, 0, 0, 32'h0, 16'hFFFE, 26'h0);
    go(32'h40);
    step("br_nt", 0, 1, 0, 0, 0, 0, 0, 32'h0, 16'hFFFE, 26'h0);
    // Taken branch beats a simultaneous jump
    step("br_pri", 0, 1, 1, 1, 1, 0, 0, 32'h0, 16'h0010, 26'h3);

    // Jump keeps region bits; stall holds
    go(32'hF000_0010);
    step("j_stall", 1, 0, 0, 1, 0, 0, 0, 32'h0, 16'h0, 26'h0000100);
    step("j_reg", 0, 0, 0, 1, 0, 0, 0, 32'h0, 16'h0, 26'h0000100);

    // link without jump is ignored
    step("link_only", 0, 0, 0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0);

    // Call / correct return
    go(32'h100);
    jal("jal1", 26'h80);
    ret("ret_ok", 32'h104);
    // Call / wrong return then pulse clears
    go(32'h100);
    jal("jal2", 26'h80);
    ret("ret_bad", 32'h108);
    seq("mis_clr");

    // Mispredict cleared by stall
    go(32'h100);
    jal("jal3", 26'h80);
    ret("ret_bad2", 32'h10C);
    step("stall_clr", 1, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);

    // Overflow: five calls into a four-deep stack
    for (int i = 1; i <= 5; i++) begin
      go(32'(i) << 4);
      jal("jal_ovf", 26'h40);
    end
    // Stall must not pop
    step("ret_stall", 1, 0, 0, 0, 0, 1, 1, 32'h54, 16'h0, 26'h0);
    // jump wins over jr: push, not pop
    step("j_vs_jr", 0, 0, 0, 1, 1, 1, 1, 32'h54, 16'h0, 26'h50);
    ret("ret_extra", 32'h304);
    for (int i = 0; i < 4; i++) begin
      want_ret = 32'h54 - 32'(i) * 32'h10;
      ret("ret_chain", want_ret);
    end
    ret("ret_empty", 32'h300);

    // Async reset with two entries held
    jal("jal_a", 26'h10);
    jal("jal_b", 26'h20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst", e0);
    #2 rst_n = 1'b1;
    seq("post_rst1");
    seq("post_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle processor. Holds the PC register and resolves the next PC from sequential, branch, jump and jump-register sources.
- Adds features the first-generation PC does not have:
  - active-low async reset to a configurable vector
  - stall/freeze
  - correctly sign-extended branch offsets
  - jump-and-link and jump-register support
- A circular return-address stack (RAS) records link addresses and provides a predicted return target plus a mispredict flag. Future pipelined fetch will use these; they are also used now for verification.

Parameters:
- XLEN, 32, PC and address width; must be >= 28.
- RESET_VECTOR, 32'h0000_0000, PC value after reset; truncated to XLEN.
- RAS_DEPTH, 4, number of return-address entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  holds PC and RAS when high
- branch  in  1  conditional branch instruction
- zero  in  1  ALU zero flag
- jump  in  1  J-type jump
- link  in  1  with jump: jal, push return address
- jr  in  1  jump-register
- is_ret  in  1  with jr: return (jr $ra), pop RAS
- jr_target  in  XLEN  register value for jr
- imm16  in  16  branch offset in words, signed
- addr26  in  26  J-type word address
- pc  out  XLEN  current PC (registered)
- pc_plus4  out  XLEN  pc + 4 (combinational)
- ras_top  out  XLEN  current RAS top entry; 0 when empty
- ras_valid  out  1  RAS non-empty
- ras_mispredict  out  1  registered, one-cycle pulse
- ras_overflow  out  1  sticky; set when a push overwrites an entry

Behaviour:
- Reset: asynchronous on rst_n low.
  - pc = RESET_VECTOR.
  - RAS count = 0, pointer = 0, all entries = 0.
  - ras_mispredict = 0, ras_overflow = 0.
  - ras_valid = 0, ras_top = 0.
  - Reset mid-operation discards all RAS contents.
- Arithmetic:
  - pc_plus4 = pc + 4, modulo 2^XLEN.
  - br_tgt = pc_plus4 + (sign_extend(imm16) << 2).
  - j_tgt = {pc_plus4[XLEN-1:28], addr26, 2'b00}.
  - jr_target is used as-is; no alignment check.
- Next-PC priority (one update per rising edge when stall = 0):
  1. branch & zero -> br_tgt
  2. jump -> j_tgt
  3. jr -> jr_target
  4. otherwise pc_plus4
  - branch with zero = 0 falls through to the lower priorities.
- Latency: pc updates on the edge after inputs are presented; pc is the only state-visible output of next-PC selection.
- RAS push: when jump & link is selected, push pc_plus4.
  - Pointer advances modulo RAS_DEPTH.
  - Count saturates at RAS_DEPTH.
  - A push at full count overwrites the oldest entry and sets ras_overflow (sticky until reset).
- RAS pop: when jr & is_ret is selected (and nothing higher-priority fires), pop.
  - If ras_valid and ras_top != jr_target, pulse ras_mispredict for exactly one cycle.
  - Pop when empty: count stays 0, no pointer change, no mispredict.
- Exclusivity: push and pop cannot occur in the same cycle; priority makes jump win over jr.
  - link without jump is ignored; is_ret without jr is ignored.
- stall = 1:
  - pc, RAS and ras_overflow hold.
  - ras_mispredict is cleared.
  - Stall overrides all redirects.
- ras_top and ras_valid reflect the current registered state (combinational from registers).

Optional Feature:
- Macro: PC_EXC_EN.
- When defined, adds these ports:
  - exc in 1
  - eret in 1
  - epc out XLEN
  - Parameter EXC_VECTOR, default 32'h0000_0080.
- exc has highest priority, above stall:
  - pc <= EXC_VECTOR
  - epc <= pc
  - RAS untouched
- eret, second priority below exc but above stall: pc <= epc.
- epc resets to 0.
- Without the macro: no such ports or state; priority is exactly as above.

Decomposition:
- Package pc_pkg holds:
  - default XLEN
  - RESET_VECTOR and EXC_VECTOR constants
  - next-PC select enum: SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC, SEL_ERET
- One sub-module: pc_ras.
  - Parameters: XLEN, RAS_DEPTH.
  - Ports: push, pop, push_data, top, valid, overflow.
  - Mispredict compare stays in pc_unit.

Test Plan:
- Reset/sequential: rst_n low, then release with RESET_VECTOR=0 -> pc 0, 4, 8, 12 on successive edges; ras_valid = 0.
- Negative branch: pc=0x40, branch=1, zero=1, imm16=16'hFFFE -> pc=0x3C. Same with zero=0 -> pc=0x44.
- Jump region: pc=0xF000_0010, jump, addr26=26'h0000100 -> pc=0xF000_0400. With stall=1 -> pc stays 0xF000_0010.
- Call/return: at pc=0x100, jal -> ras_top=0x104. Later at pc=0x200, jr/is_ret with jr_target=0x104 -> pc=0x104, ras_mispredict=0, ras_valid=0. Repeat with jr_target=0x108 -> mispredict pulses 1 cycle.
- Overflow/underflow, RAS_DEPTH=4: 5 jal at pcs 0x10,0x20,0x30,0x40,0x50 -> ras_overflow=1. Pops then return 0x54,0x44,0x34,0x24; 5th pop -> ras_valid=0, no mispredict.
- Async reset mid-stream: assert rst_n low between edges with RAS holding 2 entries -> pc=RESET_VECTOR and ras_valid=0 immediately, without waiting for clk.
